// File: rtl/sd_pkg.sv
// Shared definitions for the SD sector buffer.
//   SECTOR_BYTES  bytes per SD sector
//   SECTOR_WORDS  16-bit words served per sector
//   sdbuf_state_t controller states
package sd_pkg;
  localparam int SECTOR_BYTES = 512;
  localparam int SECTOR_WORDS = 256;

  typedef enum logic [1:0] {IDLE, HIT, ISSUE, FILL} sdbuf_state_t;
endpackage

// File: rtl/sd_sector_ram.sv
// One-sector buffer RAM: two 256x8 banks, even bytes in bank_lo and odd bytes
// in bank_hi, so one read returns a little-endian 16-bit word.
//   clk, rst  clock, asynchronous active-high reset (read register only)
//   we        byte write enable
//   waddr     byte address 0..511 (bit 0 selects the bank)
//   wdata     byte to write
//   raddr     word index 0..255
//   rdata     {byte[2*raddr+1], byte[2*raddr]}, registered, 1-cycle latency
module sd_sector_ram
  import sd_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [8:0]  waddr,
  input  logic [7:0]  wdata,
  input  logic [7:0]  raddr,
  output logic [15:0] rdata
);
  logic [7:0] bank_lo [0:SECTOR_WORDS-1];
  logic [7:0] bank_hi [0:SECTOR_WORDS-1];

  always_ff @(posedge clk) begin
    if (we && !waddr[0]) bank_lo[waddr[8:1]] <= wdata;
    if (we && waddr[0])  bank_hi[waddr[8:1]] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata <= '0;
    else     rdata <= {bank_hi[raddr], bank_lo[raddr]};
  end
endmodule

// File: rtl/sd_sector_buffer.sv
// Single-sector read cache between the disk-emulation controller and the SD
// sector reader. A request for the cached LBA completes from RAM; a miss
// drives the reader's rstart/rsector handshake, captures the 512-byte stream
// and tags the buffer with the LBA once a complete sector has arrived.
//   clk, rst                 clock, asynchronous active-high reset
//   req, lba, invalidate     request interface (sampled while busy=0)
//   busy, done, err          status; done/err are exclusive 1-cycle pulses
//   rd_addr, rd_data         word read port, 1-cycle latency
//   sd_rstart, sd_rsector    command to the sector reader
//   sd_rbusy, sd_rdone       reader status
//   sd_outen/addr/byte       reader byte stream
module sd_sector_buffer
  import sd_pkg::*;
#(
  parameter logic [23:0] WDOG_CYCLES = 24'd12_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [31:0] lba,
  input  logic        invalidate,
  output logic        busy,
  output logic        done,
  output logic        err,
  input  logic [7:0]  rd_addr,
  output logic [15:0] rd_data,
  output logic        sd_rstart,
  output logic [31:0] sd_rsector,
  input  logic        sd_rbusy,
  input  logic        sd_rdone,
  input  logic        sd_outen,
  input  logic [8:0]  sd_outaddr,
  input  logic [7:0]  sd_outbyte
);
  localparam logic [9:0]  CNT_FULL  = 10'(SECTOR_BYTES);
  localparam logic [23:0] WDOG_LAST = WDOG_CYCLES - 24'd1;

  sdbuf_state_t state, state_nx;
  logic [31:0]  req_lba, tag;
  logic         tag_valid;
  logic [9:0]   byte_cnt, cnt_nx;
  logic [23:0]  wdog;
  logic         wr_en, is_hit, take_req, fill_start, fill_ok, done_nx, err_nx;

  assign wr_en      = (state == FILL) && sd_outen;
  // invalidate in the same cycle as req wins, so the request misses
  assign is_hit     = tag_valid && !invalidate && (tag == lba);
  assign sd_rsector = req_lba;

  // Byte count including a strobe in the current cycle. A strobe at address 0
  // marks a reader retry restarting the sector, so counting restarts at 1.
  always_comb begin
    cnt_nx = byte_cnt;
    if (wr_en) begin
      if (sd_outaddr == 9'd0)      cnt_nx = 10'd1;
      else if (byte_cnt != CNT_FULL) cnt_nx = byte_cnt + 10'd1;
    end
  end

  always_comb begin
    state_nx   = state;
    take_req   = 1'b0;
    fill_start = 1'b0;
    fill_ok    = 1'b0;
    done_nx    = 1'b0;
    err_nx     = 1'b0;
    sd_rstart  = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          take_req = 1'b1;
          state_nx = is_hit ? HIT : ISSUE;
        end
      end
      HIT: begin
        done_nx  = 1'b1;
        state_nx = IDLE;
      end
      ISSUE: begin
        // rstart is combinational so it drops in the very cycle rbusy rises
        if (sd_rbusy) begin
          fill_start = 1'b1;
          state_nx   = FILL;
        end else begin
          sd_rstart = 1'b1;
        end
      end
      FILL: begin
        if (sd_rdone) begin
          state_nx = IDLE;
          if (cnt_nx == CNT_FULL) begin
            fill_ok = 1'b1;
            done_nx = 1'b1;
          end else begin
            err_nx = 1'b1;
          end
        end else if (wdog == WDOG_LAST) begin
          err_nx   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      tag_valid <= 1'b0;
      req_lba   <= '0;
      byte_cnt  <= '0;
      wdog      <= '0;
    end else begin
      busy <= (state_nx != IDLE);
      done <= done_nx;
      err  <= err_nx;
      if (take_req) req_lba <= lba;
      // a miss drops the tag before the RAM starts being overwritten
      if (fill_ok)
        tag_valid <= 1'b1;
      else if (((state == IDLE) && invalidate) || (take_req && !is_hit))
        tag_valid <= 1'b0;
      if (fill_start) begin
        byte_cnt <= '0;
        wdog     <= '0;
      end else if (state == FILL) begin
        byte_cnt <= cnt_nx;
        wdog     <= wdog + 24'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_ok) tag <= req_lba;
  end

  sd_sector_ram u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .waddr (sd_outaddr),
    .wdata (sd_outbyte),
    .raddr (rd_addr),
    .rdata (rd_data)
  );
endmodule

// File: tb/tb_sd_sector_buffer.sv
// Testbench for sd_sector_buffer: table-driven transactions, hand-written
// watchdog / reset / stray-strobe sequences, and randomized transactions
// checked against a sector/tag model held in the bench.
module tb_sd_sector_buffer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [31:0] lba = '0;
  logic        invalidate = 1'b0;
  logic        busy, done, err;
  logic [7:0]  rd_addr = '0;
  logic [15:0] rd_data;
  logic        sd_rstart;
  logic [31:0] sd_rsector;
  logic        sd_rbusy = 1'b0;
  logic        sd_rdone = 1'b0;
  logic        sd_outen = 1'b0;
  logic [8:0]  sd_outaddr = '0;
  logic [7:0]  sd_outbyte = '0;

  always #5 clk = ~clk;

  sd_sector_buffer #(.WDOG_CYCLES(24'd1000)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .lba        (lba),
    .invalidate (invalidate),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .sd_rstart  (sd_rstart),
    .sd_rsector (sd_rsector),
    .sd_rbusy   (sd_rbusy),
    .sd_rdone   (sd_rdone),
    .sd_outen   (sd_outen),
    .sd_outaddr (sd_outaddr),
    .sd_outbyte (sd_outbyte)
  );

  // reference model: sector contents as written by the reader, and the cache tag
  logic [7:0]  mem_m [0:511];
  logic [31:0] tag_m = '0;
  bit          valid_m = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] lba;
    bit          inv;
    int          nbytes;
    int          retry_n;
    bit          with_last;
    bit          exp_hit;
    bit          exp_done;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    #2;
    rst = 1'b1; req = 1'b0; invalidate = 1'b0;
    sd_rbusy = 1'b0; sd_rdone = 1'b0; sd_outen = 1'b0;
    cyc();
    rst = 1'b0;
    valid_m = 1'b0;
  endtask

  // wait out a stuck request; a timeout forces a reset so later tests still run
  task automatic settle();
    int k = 0;
    while (busy === 1'b1 && k < 1200) begin cyc(); k++; end
    if (busy !== 1'b0) begin
      chk("settle_busy", 32'(busy), 32'd0);
      pulse_reset();
    end
  endtask

  // reader byte stream at addresses 0..n-1, occasional idle gaps
  task automatic stream(input int n, input bit done_last);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 7) == 0) begin sd_outen = 1'b0; cyc(); end
      sd_outen   = 1'b1;
      sd_outaddr = 9'(i);
      sd_outbyte = 8'($urandom);
      mem_m[i]   = sd_outbyte;
      if (done_last && i == n - 1) sd_rdone = 1'b1;
      cyc();
    end
    sd_outen = 1'b0;
  endtask

  task automatic check_ram(input string nm);
    logic [7:0]  a;
    logic [15:0] exp;
    for (int j = 0; j < 4; j++) begin
      a = (j == 0) ? 8'd0 : (j == 1) ? 8'd255 : 8'($urandom);
      rd_addr = a;
      cyc();
      exp = {mem_m[2*int'(a)+1], mem_m[2*int'(a)]};
      chk($sformatf("%s_rd[%0d]", nm, a), 32'(rd_data), 32'(exp));
    end
  endtask

  task automatic txn(input string nm, input logic [31:0] a, input bit inv,
                     input int nbytes, input int retry_n, input bit with_last,
                     input bit exp_hit, input bit exp_done);
    int w;
    req = 1'b1; lba = a; invalidate = inv;
    cyc();
    req = 1'b0; invalidate = 1'b0;
    chk({nm, "_busy"}, 32'(busy), 32'd1);
    if (exp_hit) begin
      chk({nm, "_hit_nostart"}, 32'(sd_rstart), 32'd0);
      cyc();
      chk({nm, "_hit_done"}, 32'(done), 32'd1);
      chk({nm, "_hit_busy"}, 32'(busy), 32'd0);
      chk({nm, "_hit_nostart2"}, 32'(sd_rstart), 32'd0);
      cyc();
      chk({nm, "_hit_pulse"}, 32'(done), 32'd0);
    end else begin
      w = 0;
      while (sd_rstart !== 1'b1 && w < 20) begin cyc(); w++; end
      chk({nm, "_rstart"}, 32'(sd_rstart), 32'd1);
      chk({nm, "_rsector"}, sd_rsector, a);
      if (sd_rstart !== 1'b1) return;
      repeat ($urandom_range(0, 3)) begin
        cyc();
        chk({nm, "_rstart_held"}, 32'(sd_rstart), 32'd1);
      end
      sd_rbusy = 1'b1;
      #1 chk({nm, "_rstart_drop"}, 32'(sd_rstart), 32'd0);
      cyc();
      if (retry_n > 0) stream(retry_n, 1'b0);
      stream(nbytes, with_last);
      if (!with_last) begin sd_rdone = 1'b1; cyc(); end
      sd_rdone = 1'b0;
      sd_rbusy = 1'b0;
      chk({nm, "_done"}, 32'(done), 32'(exp_done));
      chk({nm, "_err"}, 32'(err), 32'(!exp_done));
      chk({nm, "_busy_end"}, 32'(busy), 32'd0);
      cyc();
      chk({nm, "_pulse"}, 32'({done, err}), 32'd0);
      if (exp_done) begin tag_m = a; valid_m = 1'b1; end
      else valid_m = 1'b0;
    end
  endtask

  initial begin
    int first;
    logic [31:0] a;
    bit inv, hit;
    int kind, nb, rn;

    tbl[0] = '{32'h0000_1234, 1'b0, 512,   0, 1'b0, 1'b0, 1'b1}; // cold miss
    tbl[1] = '{32'h0000_1234, 1'b0, 512,   0, 1'b0, 1'b1, 1'b1}; // hit
    tbl[2] = '{32'h0000_00AB, 1'b0, 300,   0, 1'b0, 1'b0, 1'b0}; // short sector
    tbl[3] = '{32'h0000_00AB, 1'b0, 512,   0, 1'b1, 1'b0, 1'b1}; // reissue, rdone on last strobe
    tbl[4] = '{32'h0000_1234, 1'b0, 512, 100, 1'b0, 1'b0, 1'b1}; // reader retry
    tbl[5] = '{32'h0000_1234, 1'b1, 512,   0, 1'b0, 1'b0, 1'b1}; // invalidate+req misses
    tbl[6] = '{32'h0000_1234, 1'b0, 512,   0, 1'b0, 1'b1, 1'b1}; // hit again
    tbl[7] = '{32'hFFFF_FFFF, 1'b0, 511,   0, 1'b1, 1'b0, 1'b0}; // one byte short

    // reset values
    cyc(2);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done_err", 32'({done, err}), 32'd0);
    chk("rst_rstart", 32'(sd_rstart), 32'd0);
    chk("rst_rsector", sd_rsector, 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    rst = 1'b0;
    cyc();

    for (int i = 0; i < 8; i++) begin
      txn($sformatf("tbl%0d", i), tbl[i].lba, tbl[i].inv, tbl[i].nbytes,
          tbl[i].retry_n, tbl[i].with_last, tbl[i].exp_hit, tbl[i].exp_done);
      settle();
      check_ram($sformatf("tbl%0d", i));
    end

    // strobes while idle must not reach the RAM
    sd_outaddr = 9'd0; sd_outbyte = ~mem_m[0]; sd_outen = 1'b1;
    cyc(3);
    sd_outen = 1'b0;
    check_ram("stray");

    // watchdog: err exactly 1000 cycles after FILL entry, no rdone
    req = 1'b1; lba = 32'h777; cyc(); req = 1'b0;
    chk("wd_rstart", 32'(sd_rstart), 32'd1);
    sd_rbusy = 1'b1;
    first = -1;
    for (int k = 0; k <= 1100 && first < 0; k++) begin
      cyc();
      if (err === 1'b1) first = k;
    end
    chk("wd_cycles", 32'(first), 32'd1000);
    chk("wd_nodone", 32'(done), 32'd0);
    chk("wd_busy", 32'(busy), 32'd0);
    cyc();
    chk("wd_pulse", 32'(err), 32'd0);
    sd_rbusy = 1'b0;
    valid_m = 1'b0;
    settle();

    // reset while idle drops the tag
    txn("rs_fill", 32'h1234, 1'b1, 512, 0, 1'b0, 1'b0, 1'b1);
    settle();
    pulse_reset();
    chk("rs_idle_busy", 32'(busy), 32'd0);
    txn("rs_after", 32'h1234, 1'b0, 512, 0, 1'b0, 1'b0, 1'b1);
    settle();

    // reset mid-FILL after 200 bytes
    req = 1'b1; lba = 32'h9999; cyc(); req = 1'b0;
    chk("mf_rstart", 32'(sd_rstart), 32'd1);
    sd_rbusy = 1'b1; cyc();
    stream(200, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("mf_busy", 32'(busy), 32'd0);
    chk("mf_rstart_low", 32'(sd_rstart), 32'd0);
    chk("mf_done_err", 32'({done, err}), 32'd0);
    cyc(); rst = 1'b0; sd_rbusy = 1'b0; valid_m = 1'b0;
    check_ram("mf");

    // invalidate+req misses; reset during ISSUE drops rstart without a clock edge
    req = 1'b1; invalidate = 1'b1; lba = 32'h1234; cyc(); req = 1'b0; invalidate = 1'b0;
    chk("ir_rstart", 32'(sd_rstart), 32'd1);
    chk("ir_rsector", sd_rsector, 32'h1234);
    #2 rst = 1'b1;
    #1;
    chk("ir_async_rstart", 32'(sd_rstart), 32'd0);
    chk("ir_async_rsector", sd_rsector, 32'd0);
    cyc(); rst = 1'b0;

    // randomized transactions against the model
    for (int i = 0; i < 10; i++) begin
      kind = $urandom_range(0, 2);
      a    = (kind == 0) ? 32'h1234 : (kind == 1) ? 32'hAB : $urandom;
      inv  = ($urandom_range(0, 4) == 0);
      hit  = valid_m && !inv && (tag_m == a);
      kind = $urandom_range(0, 3);
      nb   = (kind == 0) ? $urandom_range(1, 511) : 512;
      rn   = (kind == 1) ? $urandom_range(1, 200) : 0;
      txn($sformatf("rnd%0d", i), a, inv, nb, rn, 1'($urandom_range(0, 1)), hit, (nb == 512));
      settle();
      check_ram($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
